wb_mem_test_master: RTL and testbench

//  Wishbone classic-cycle initiator that exercises a memory-mapped SRAM slave with a write pass then a read/compare pass.

---
 rtl/mem_test_pkg.sv | 23 ++
 rtl/mem_test_pattern_gen.sv | 27 ++
 rtl/wb_mem_test_master.sv | 208 ++++++++++++++++++++
 tb/tb_wb_mem_test_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared encodings for the Wishbone memory self-test engine:
// pattern modes and the master FSM states.
package mem_test_pkg;

   typedef enum logic [1:0] {
      MODE_ADDR = 2'd0,
      MODE_PAT  = 2'd1,
      MODE_INV  = 2'd2,
      MODE_ALT  = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_GAP,
      ST_RD,
      ST_RD_GAP,
      ST_FIN
   } state_e;

   localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_test_pattern_gen.sv
// Combinational test-data generator; the same instance supplies write data
// and the expected value for read compares.
module mem_test_pattern_gen
   import mem_test_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic [1:0]    mode,
   input  logic [DW-1:0] pattern,
   input  logic          idx_odd,
   input  logic [AW-1:0] adr,
   output logic [DW-1:0] data
);

   always_comb begin
      // NOTE: assign a default first so every path drives data and no latch is inferred.
      data = pattern;
      case (mode_e'(mode))
         MODE_ADDR: data = DW'(adr);
         MODE_PAT:  data = pattern;
         MODE_INV:  data = ~pattern;
         MODE_ALT:  data = idx_odd ? ~pattern : pattern;
      endcase
   end

endmodule

// File: rtl/wb_mem_test_master.sv
// Wishbone classic initiator: writes a pattern over a word range, reads it
// back and compares, reporting pass/fail, error count and first failure.
module wb_mem_test_master
   import mem_test_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             start_i,
   input  logic [AW-1:0]    base_adr_i,
   input  logic [CNT_W-1:0] word_cnt_i,
   input  logic [1:0]       mode_i,
   input  logic [DW-1:0]    pattern_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [AW-1:0]    fail_adr_o,
   output logic [DW-1:0]    fail_exp_o,
   output logic [DW-1:0]    fail_got_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [AW-1:0]    wbm_adr_o,
   output logic [DW-1:0]    wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic [DW-1:0]    wbm_dat_i
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e           state;
   logic [AW-1:0]    base_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] idx;
   logic [1:0]       mode_q;
   logic [DW-1:0]    pat_q;
   logic [TW-1:0]    tmo_cnt;

   logic             idle;
   logic [1:0]       gen_mode;
   logic [DW-1:0]    gen_pat;
   logic             gen_odd;
   logic [AW-1:0]    gen_adr;
   logic [DW-1:0]    gen_data;
   logic             tmo_hit;

   // In IDLE the generator looks at the live inputs so the first write can
   // be issued in the cycle right after start.
   always_comb begin
      idle     = (state == ST_IDLE);
      gen_mode = idle ? mode_i : mode_q;
      gen_pat  = idle ? pattern_i : pat_q;
      gen_odd  = idle ? 1'b0 : idx[0];
      gen_adr  = idle ? (base_adr_i & ~AW'(3)) : (base_q + (AW'(idx) << 2));
      tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
   end

   mem_test_pattern_gen #(
      .DW(DW),
      .AW(AW)
   ) u_pattern_gen (
      .mode    (gen_mode),
      .pattern (gen_pat),
      .idx_odd (gen_odd),
      .adr     (gen_adr),
      .data    (gen_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state      <= ST_IDLE;
         base_q     <= '0;
         cnt_q      <= '0;
         idx        <= '0;
         mode_q     <= '0;
         pat_q      <= '0;
         tmo_cnt    <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         timeout_o  <= 1'b0;
         err_cnt_o  <= '0;
         fail_adr_o <= '0;
         fail_exp_o <= '0;
         fail_got_o <= '0;
         wbm_cyc_o  <= 1'b0;
         wbm_stb_o  <= 1'b0;
         wbm_we_o   <= 1'b0;
         wbm_sel_o  <= '0;
         wbm_adr_o  <= '0;
         wbm_dat_o  <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  base_q     <= gen_adr;
                  cnt_q      <= word_cnt_i;
                  mode_q     <= mode_i;
                  pat_q      <= pattern_i;
                  idx        <= '0;
                  tmo_cnt    <= '0;
                  err_cnt_o  <= '0;
                  fail_adr_o <= '0;
                  fail_exp_o <= '0;
                  fail_got_o <= '0;
                  timeout_o  <= 1'b0;
                  busy_o     <= 1'b1;
                  if (word_cnt_i == '0) begin
                     pass_o <= 1'b1;
                     done_o <= 1'b1;
                     state  <= ST_FIN;
                  end else begin
                     pass_o    <= 1'b0;
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     wbm_we_o  <= 1'b1;
                     wbm_sel_o <= SEL_ALL;
                     wbm_adr_o <= gen_adr;
                     wbm_dat_o <= gen_data;
                     state     <= ST_WR;
                  end
               end
            end

            ST_WR, ST_RD: begin
               if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= '0;
                  idx       <= idx + CNT_W'(1);
                  state     <= (state == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
                  // Read compare happens on the ack cycle; gen_data tracks wbm_adr_o here.
                  if (state == ST_RD && wbm_dat_i != gen_data) begin
                     if (err_cnt_o == '0) begin
                        fail_adr_o <= wbm_adr_o;
                        fail_exp_o <= gen_data;
                        fail_got_o <= wbm_dat_i;
                     end
                     if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
                  end
               end else if (tmo_hit) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= '0;
                  timeout_o <= 1'b1;
                  pass_o    <= 1'b0;
                  done_o    <= 1'b1;
                  state     <= ST_FIN;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            ST_WR_GAP: begin
               tmo_cnt   <= '0;
               wbm_cyc_o <= 1'b1;
               wbm_stb_o <= 1'b1;
               wbm_sel_o <= SEL_ALL;
               if (idx == cnt_q) begin
                  idx       <= '0;
                  wbm_we_o  <= 1'b0;
                  wbm_adr_o <= base_q;
                  state     <= ST_RD;
               end else begin
                  wbm_we_o  <= 1'b1;
                  wbm_adr_o <= gen_adr;
                  wbm_dat_o <= gen_data;
                  state     <= ST_WR;
               end
            end

            ST_RD_GAP: begin
               tmo_cnt <= '0;
               if (idx == cnt_q) begin
                  pass_o <= (err_cnt_o == '0);
                  done_o <= 1'b1;
                  state  <= ST_FIN;
               end else begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_sel_o <= SEL_ALL;
                  wbm_adr_o <= gen_adr;
                  state     <= ST_RD;
               end
            end

            ST_FIN: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_mem_test_master.sv
// Self-checking bench: zero-wait RAM slave model, scoreboard of expected bus
// transfers and per-test results popped as the master produces them.
module tb_wb_mem_test_master;

   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 255;

   logic             wb_clk_i = 1'b0;
   logic             wb_rst_ni = 1'b0;
   logic             start_i = 1'b0;
   logic [AW-1:0]    base_adr_i = '0;
   logic [CNT_W-1:0] word_cnt_i = '0;
   logic [1:0]       mode_i = '0;
   logic [DW-1:0]    pattern_i = '0;
   logic             busy_o, done_o, pass_o, timeout_o;
   logic [CNT_W-1:0] err_cnt_o;
   logic [AW-1:0]    fail_adr_o;
   logic [DW-1:0]    fail_exp_o, fail_got_o;
   logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]       wbm_sel_o;
   logic [AW-1:0]    wbm_adr_o;
   logic [DW-1:0]    wbm_dat_o;
   logic             wbm_ack_i;
   logic [DW-1:0]    wbm_dat_i;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } xfer_t;

   typedef struct {
      logic        pass;
      logic        tmo;
      logic [15:0] err;
      logic [31:0] fadr;
      logic [31:0] fexp;
      logic [31:0] fgot;
   } res_t;

   xfer_t       wq[$];
   logic [31:0] rq[$];
   res_t        resq[$];

   int          n_checks = 0;
   int          n_pass = 0;
   int          bus_cycles = 0;
   bit          ack_en = 1'b1;
   bit          flip_en = 1'b0;
   logic [31:0] flip_adr = '0;
   logic [31:0] mem [0:255];

   always #5 wb_clk_i = ~wb_clk_i;

   wb_mem_test_master #(
      .DW(DW), .AW(AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_ni  (wb_rst_ni),
      .start_i    (start_i),
      .base_adr_i (base_adr_i),
      .word_cnt_i (word_cnt_i),
      .mode_i     (mode_i),
      .pattern_i  (pattern_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .pass_o     (pass_o),
      .timeout_o  (timeout_o),
      .err_cnt_o  (err_cnt_o),
      .fail_adr_o (fail_adr_o),
      .fail_exp_o (fail_exp_o),
      .fail_got_o (fail_got_o),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_ack_i  (wbm_ack_i),
      .wbm_dat_i  (wbm_dat_i)
   );

   // Zero-wait slave: ack in the same cycle stb is seen, optional bit0 corruption on one read address.
   assign wbm_ack_i = ack_en & wbm_cyc_o & wbm_stb_o;
   always_comb
      wbm_dat_i = mem[wbm_adr_o[9:2]] ^ {31'b0, (flip_en && !wbm_we_o && wbm_adr_o == flip_adr)};

   always @(posedge wb_clk_i)
      if (wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i) mem[wbm_adr_o[9:2]] <= wbm_dat_o;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] exp_pat(input logic [1:0] m, input logic [31:0] p,
                                           input int i, input logic [31:0] a);
      case (m)
         2'd0:    return a;
         2'd1:    return p;
         2'd2:    return ~p;
         default: return (i % 2 == 1) ? ~p : p;
      endcase
   endfunction

   // Bus monitor: every acked transfer pops the next expected write or read.
   always @(negedge wb_clk_i) begin
      if (wb_rst_ni && wbm_cyc_o && wbm_stb_o) begin
         bus_cycles++;
         if (wbm_ack_i) begin
            check("sel", {60'b0, wbm_sel_o}, 64'hF);
            if (wbm_we_o) begin
               if (wq.size() == 0) check("wr_unexpected", {32'b0, wbm_adr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
               else begin
                  xfer_t e;
                  e = wq.pop_front();
                  check("wr_adr", {32'b0, wbm_adr_o}, {32'b0, e.adr});
                  check("wr_dat", {32'b0, wbm_dat_o}, {32'b0, e.dat});
               end
            end else begin
               if (rq.size() == 0) check("rd_unexpected", {32'b0, wbm_adr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
               else check("rd_adr", {32'b0, wbm_adr_o}, {32'b0, rq.pop_front()});
            end
         end
      end
   end

   task automatic push_expected(input logic [31:0] base, input int cnt, input logic [1:0] mode,
                                input logic [31:0] pat);
      res_t  r;
      xfer_t x;
      logic [31:0] a;
      r.pass = 1'b1; r.tmo = 1'b0; r.err = '0; r.fadr = '0; r.fexp = '0; r.fgot = '0;
      if (!ack_en && cnt > 0) begin
         r.pass = 1'b0;
         r.tmo  = 1'b1;
      end else begin
         for (int i = 0; i < cnt; i++) begin
            a = (base & ~32'd3) + 32'(4 * i);
            x.adr = a;
            x.dat = exp_pat(mode, pat, i, a);
            wq.push_back(x);
            rq.push_back(a);
            if (flip_en && a == flip_adr) begin
               if (r.err == 0) begin
                  r.fadr = a; r.fexp = x.dat; r.fgot = x.dat ^ 32'd1;
               end
               r.err++;
            end
         end
         r.pass = (r.err == 0);
      end
      resq.push_back(r);
   endtask

   task automatic run_test(input string name, input logic [31:0] base, input int cnt,
                           input logic [1:0] mode, input logic [31:0] pat, input int poke_at);
      int   lat;
      int   exp_lat;
      int   exp_bus;
      res_t r;
      bus_cycles = 0;
      push_expected(base, cnt, mode, pat);
      @(negedge wb_clk_i);
      start_i = 1'b1; base_adr_i = base; word_cnt_i = CNT_W'(cnt); mode_i = mode; pattern_i = pat;
      lat = 0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge wb_clk_i);
         start_i = (c == poke_at);
         if (c == poke_at) begin
            word_cnt_i = '0;
            base_adr_i = 32'h200;
         end
         if (done_o) begin
            lat = c;
            break;
         end
      end
      start_i = 1'b0;
      if (lat == 0) check({name, "_done_wait"}, {63'b0, done_o}, 64'd1);
      exp_lat = (!ack_en && cnt > 0) ? TIMEOUT + 1 : 1 + 4 * cnt;
      exp_bus = ack_en ? 2 * cnt : ((cnt > 0) ? TIMEOUT : 0);
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_bus_cycles"}, 64'(bus_cycles), 64'(exp_bus));
      check({name, "_busy_fin"}, {63'b0, busy_o}, 64'd1);
      r = resq.pop_front();
      check({name, "_pass"}, {63'b0, pass_o}, {63'b0, r.pass});
      check({name, "_timeout"}, {63'b0, timeout_o}, {63'b0, r.tmo});
      check({name, "_err_cnt"}, {48'b0, err_cnt_o}, {48'b0, r.err});
      check({name, "_fail_adr"}, {32'b0, fail_adr_o}, {32'b0, r.fadr});
      check({name, "_fail_exp"}, {32'b0, fail_exp_o}, {32'b0, r.fexp});
      check({name, "_fail_got"}, {32'b0, fail_got_o}, {32'b0, r.fgot});
      @(negedge wb_clk_i);
      check({name, "_busy_after"}, {63'b0, busy_o}, 64'd0);
      check({name, "_done_pulse"}, {63'b0, done_o}, 64'd0);
      check({name, "_pass_held"}, {63'b0, pass_o}, {63'b0, r.pass});
      check({name, "_cyc_idle"}, {63'b0, wbm_cyc_o}, 64'd0);
      check({name, "_wq_left"}, 64'(wq.size()), 64'd0);
      check({name, "_rq_left"}, 64'(rq.size()), 64'd0);
      wq.delete();
      rq.delete();
   endtask

   initial begin
      bit found;
      #1;
      check("rst_ctrl", {56'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, pass_o, timeout_o, 1'b0}, 64'd0);
      check("rst_sel_err", {44'b0, wbm_sel_o, err_cnt_o}, 64'd0);
      check("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'd0);
      check("rst_fail", {fail_adr_o, fail_exp_o ^ fail_got_o}, 64'd0);
      #20 wb_rst_ni = 1'b1;

      run_test("addr4", 32'h0, 4, 2'd0, 32'h0, 5);
      run_test("alt3", 32'h0001_0000, 3, 2'd3, 32'hA5A5_A5A5, 0);

      flip_en = 1'b1; flip_adr = 32'h8;
      run_test("corrupt", 32'h0, 4, 2'd0, 32'h0, 0);
      flip_en = 1'b0;

      run_test("cnt0", 32'h100, 0, 2'd1, 32'h1234_5678, 0);

      ack_en = 1'b0;
      run_test("no_ack", 32'h20, 2, 2'd1, 32'hDEAD_BEEF, 20);
      ack_en = 1'b1;

      // Reset in the middle of the read pass, after one mismatch has been captured.
      flip_en = 1'b1; flip_adr = 32'h40;
      push_expected(32'h40, 4, 2'd0, 32'h0);
      @(negedge wb_clk_i);
      start_i = 1'b1; base_adr_i = 32'h40; word_cnt_i = 16'd4; mode_i = 2'd0;
      @(negedge wb_clk_i);
      start_i = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (wbm_stb_o && !wbm_we_o && wbm_adr_o == 32'h44) begin
            found = 1'b1;
            break;
         end
         @(negedge wb_clk_i);
      end
      check("mid_rd_reached", {63'b0, wbm_stb_o & ~wbm_we_o}, 64'd1);
      check("mid_rd_err_seen", {48'b0, err_cnt_o}, 64'd1);
      #2 wb_rst_ni = 1'b0;
      #1;
      check("arst_ctrl", {56'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, pass_o, timeout_o, 1'b0}, 64'd0);
      check("arst_err", {48'b0, err_cnt_o}, 64'd0);
      check("arst_fail", {fail_adr_o, fail_exp_o | fail_got_o}, 64'd0);
      check("arst_adr", {32'b0, wbm_adr_o}, 64'd0);
      wq.delete(); rq.delete(); resq.delete();
      flip_en = 1'b0;
      @(negedge wb_clk_i);
      wb_rst_ni = 1'b1;

      run_test("pat2", 32'h80, 2, 2'd1, 32'h1234_5678, 0);
      run_test("inv2", 32'hC3, 2, 2'd2, 32'h1234_5678, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
